mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store initiator between the MIPS datapath MEM stage and the word-addressed Data_Memory block.
- Accepts one byte, halfword or word access per request.
- Drives the memory's address, data_in, MemRead and MemWrite; sign- or zero-extends load data.
- Implements sb/sh as read-modify-write over two memory cycles. Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 1024, depth of the attached memory in 32-bit words; byte addresses >= MEM_WORDS*4 are out of range.
- STAT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted on a clk edge where req_valid && req_ready
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte/half taken from low bits
- resp_valid  out  1  one-cycle pulse, completion of the accepted request
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or reserved size
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
- mem_address  out  32  to Data_Memory address (word-aligned: bits[1:0]=00)
- mem_data_in  out  32  to Data_Memory data_in
- mem_read  out  1  to Data_Memory MemRead
- mem_write  out  1  to Data_Memory MemWrite
- mem_read_data  in  32  from Data_Memory read_data (combinational read while mem_read=1)

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. All outputs decode from registered state and latched request only.
- Reset: state=IDLE. req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_data_in=0. Latched request is cleared.
- IDLE: on accept, latch addr/size/signed/write/wdata and check errors.
  - Error if size=11, half with addr[0]=1, word with addr[1:0]!=00, or addr >= MEM_WORDS*4. Error -> RESP with err=1, no memory strobe.
  - Load -> READ. Word store -> WRITE. Byte/half store -> READ.
- READ (1 cycle): mem_read=1, mem_address={addr[31:2],2'b00}. Capture mem_read_data at end of cycle. Load -> RESP. Sub-word store -> WRITE.
- WRITE (1 cycle): mem_write=1. mem_data_in = wdata for a word store; for a sub-word store, the captured word with the addressed lane(s) replaced. Next -> RESP.
- RESP (1 cycle): resp_valid=1, then -> IDLE. req_ready=0 in every state except IDLE, so there is no back-to-back accept.
- Byte order: little-endian. Byte lane n = bits[8n+7:8n], n=addr[1:0]. Half lane = addr[1] (bits[15:0] or [31:16]).
- Load extension: byte/half sign-extend from the lane MSB when req_signed=1, else zero-fill. Word loads ignore req_signed.
- Latency from accept edge to resp_valid:
  - error: 1 cycle
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
- mem_read and mem_write are never both 1. Neither strobe is asserted in IDLE or RESP.
- Reset mid-operation returns to IDLE immediately. A store in READ is abandoned with no write. Reset during WRITE: the memory's reset takes priority, so no write occurs. No resp_valid is issued for an aborted request.
- req_* changes while busy are ignored; the latched copy is used.

Optional Feature:
- Macro MAU_STATS_EN.
- Defined: adds outputs stat_loads, stat_stores, stat_errors (STAT_W each, reset 0). Each increments by 1 in the RESP cycle of the matching request (errors count only in stat_errors) and saturates at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Preload word 0 = 32'h8012_34F0; load byte signed addr 0 -> resp_rdata=32'hFFFF_FFF0, resp_err=0, resp_valid 2 cycles after accept; same request unsigned -> 32'h0000_00F0.
- Store byte 8'hAB at addr 2 over word 0 -> one mem_read cycle then one mem_write cycle with mem_data_in=32'h80AB_34F0; resp_valid 3 cycles after accept; word load addr 0 returns 32'h80AB_34F0.
- Load half signed addr 2 of 32'h8012_34F0 -> 32'hFFFF_8012. Word store 32'hDEAD_BEEF at addr 4 -> single mem_write, mem_address=4, resp_valid 2 cycles after accept.
- Word load addr 6, half store addr 1, size=11, and word load addr 4096 (MEM_WORDS=1024) -> each gives resp_err=1 one cycle after accept with no mem_read/mem_write pulse; memory unchanged.
- Assert reset during READ of a byte store to addr 0 -> no mem_write and no resp_valid; req_ready=1 after reset; word 0 unchanged.
- With MAU_STATS_EN: 3 loads, 2 stores, 1 error -> stat_loads=3, stat_stores=2, stat_errors=1; with STAT_W forced to 2 and 5 loads, stat_loads stays at 3.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store initiator between the MEM stage and a word-addressed
//               data memory. Sub-word stores are read-modify-write. Define
//               MAU_STATS_EN to add saturating load/store/error counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int MEM_WORDS = 1024,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data
`ifdef MAU_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_loads,
    output logic [STAT_W-1:0] stat_stores,
    output logic [STAT_W-1:0] stat_errors
`endif
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_read  = 2'd1;
    localparam logic [1:0]  c_st_write = 2'd2;
    localparam logic [1:0]  c_st_resp  = 2'd3;
    localparam logic [32:0] c_addr_limit = 33'(MEM_WORDS) * 33'd4;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_req_err = (req_size == 2'b11)
                     | ((req_size == 2'b01) & req_addr[0])
                     | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                     | ({1'b0, req_addr} >= c_addr_limit);

    // Lane selection uses the latched address; memory returns the whole word.
    assign w_byte = mem_read_data[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_read_data[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = mem_read_data;
        w_merged    = mem_read_data;
        case (r_size)
            2'b00: begin
                w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
                w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            2'b01: begin
                w_load_data = {{16{r_signed & w_half[15]}}, w_half};
                w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_addr        <= '0;
            r_size        <= '0;
            r_signed      <= 1'b0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_err         <= 1'b0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= '0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_addr        <= req_addr;
                        r_size        <= req_size;
                        r_signed      <= req_signed;
                        r_write       <= req_write;
                        r_wdata       <= req_wdata;
                        r_err         <= w_req_err;
                        r_req_ready   <= 1'b0;
                        r_mem_address <= {req_addr[31:2], 2'b00};
                        if (w_req_err) begin
                            r_state      <= c_st_resp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (req_write && (req_size == 2'b10)) begin
                            r_state       <= c_st_write;
                            r_mem_write   <= 1'b1;
                            r_mem_data_in <= req_wdata;
                        end else begin
                            r_state    <= c_st_read;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                c_st_read: begin
                    r_mem_read <= 1'b0;
                    if (r_write) begin
                        r_state       <= c_st_write;
                        r_mem_write   <= 1'b1;
                        r_mem_data_in <= w_merged;
                    end else begin
                        r_state      <= c_st_resp;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_data;
                    end
                end
                c_st_write: begin
                    r_mem_write  <= 1'b0;
                    r_state      <= c_st_resp;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_state      <= c_st_idle;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;

`ifdef MAU_STATS_EN
    logic [STAT_W-1:0] r_stat_loads;
    logic [STAT_W-1:0] r_stat_stores;
    logic [STAT_W-1:0] r_stat_errors;

    // Counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_errors <= '0;
        end else if (r_state == c_st_resp) begin
            if (r_err) begin
                if (!(&r_stat_errors)) r_stat_errors <= r_stat_errors + 1'b1;
            end else if (r_write) begin
                if (!(&r_stat_stores)) r_stat_stores <= r_stat_stores + 1'b1;
            end else begin
                if (!(&r_stat_loads)) r_stat_loads <= r_stat_loads + 1'b1;
            end
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_errors = r_stat_errors;
`endif

endmodule

`default_nettype wire
